// File: rtl/fmap_replay_ctrl.sv
// Feature-map replay controller: optionally loads a frame into a single-port-per-direction
// buffer RAM, then streams it out a configurable number of passes with valid/ready flow control.
module fmap_replay_ctrl #(
    parameter int A_WIDTH    = 7,
    parameter int ADDR_WIDTH = 10,
    parameter int D_WIDTH    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cfg_fill,
    input  logic [A_WIDTH:0]      cfg_len,
    input  logic [7:0]            cfg_npass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [D_WIDTH-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [D_WIDTH-1:0]    out_data,
    output logic                  out_last,
    output logic                  ram_we,
    output logic                  ram_en_w,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [D_WIDTH-1:0]    ram_di,
    output logic                  ram_en_r,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [D_WIDTH-1:0]    ram_dat_read,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = A_WIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {A_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [7:0]           npass_q, npass_d;
    logic [7:0]           pass_q, pass_d;
    logic [A_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [A_WIDTH-1:0]   rcnt_q, rcnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic [LW-1:0]        len_sat;
    logic [LW-1:0]        len_m1;
    logic [A_WIDTH-1:0]   last_addr;
    logic                 in_fire;
    logic                 reads_left;
    logic                 slot_free;
    logic                 issue;

    assign len_sat    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    assign len_m1     = len_q - LW'(1);
    assign last_addr  = len_m1[A_WIDTH-1:0];
    assign in_fire    = (state_q == FILL) && in_valid;
    assign reads_left = pass_q < npass_q;
    // The output slot can take a new word when empty or when its current word leaves this cycle.
    assign slot_free  = !out_valid_q || out_ready;
    assign issue      = (state_q == REPLAY) && reads_left && slot_free;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        npass_d     = npass_q;
        pass_d      = pass_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len_sat;
                    npass_d = cfg_npass;
                    pass_d  = '0;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    if (len_sat == '0)
                        state_d = DONE;
                    else if (cfg_fill)
                        state_d = FILL;
                    else
                        state_d = REPLAY;
                end
            end
            FILL: begin
                if (in_valid) begin
                    wcnt_d = wcnt_q + A_WIDTH'(1);
                    if (wcnt_q == last_addr) begin
                        wcnt_d  = '0;
                        state_d = (npass_q == '0) ? DONE : REPLAY;
                    end
                end
            end
            REPLAY: begin
                if (issue) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (rcnt_q == last_addr);
                    if (rcnt_q == last_addr) begin
                        rcnt_d = '0;
                        pass_d = pass_q + 8'd1;
                    end else begin
                        rcnt_d = rcnt_q + A_WIDTH'(1);
                    end
                end else if (slot_free) begin
                    // Slot drained with no reads left: the job is finished.
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            npass_q     <= '0;
            pass_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            npass_q     <= npass_d;
            pass_q      <= pass_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign in_ready   = (state_q == FILL);
    assign ram_we     = in_fire;
    assign ram_en_w   = in_fire;
    assign ram_addr_w = ADDR_WIDTH'(wcnt_q);
    assign ram_di     = in_fire ? in_data : '0;
    assign ram_en_r   = issue;
    assign ram_addr_r = ADDR_WIDTH'(rcnt_q);
    // RAM read data holds while no read is issued, so it doubles as the output data register.
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_valid_q ? ram_dat_read : '0;

endmodule

// File: doc/fmap_replay_ctrl.md
FMAP_REPLAY_CTRL -- requirements
Module: fmap_replay_ctrl

Interface
REQ-001 SHALL have parameter A_WIDTH, default 7, meaning log2 of the buffer RAM depth in words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the RAM address port width (ADDR_WIDTH >= A_WIDTH).
REQ-003 SHALL have parameter D_WIDTH, default 15, meaning the data word width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle job launch, sampled in IDLE only.
REQ-007 SHALL have port cfg_fill  input  1  at start: 1 = load a new frame then replay, 0 = replay the stored frame.
REQ-008 SHALL have port cfg_len  input  A_WIDTH+1  frame length in words, sampled at start.
REQ-009 SHALL have port cfg_npass  input  8  number of replay passes, sampled at start.
REQ-010 SHALL have port in_valid / in_ready / in_data  input / output / input  1 / 1 / D_WIDTH  frame load stream.
REQ-011 SHALL have port out_valid / out_ready / out_data / out_last  output / input / output / output  1 / 1 / D_WIDTH / 1  replay stream; out_last marks the final word of each pass.
REQ-012 SHALL have ports ram_we, ram_en_w, ram_addr_w[ADDR_WIDTH], ram_di[D_WIDTH]  outputs  RAM write port drive.
REQ-013 SHALL have ports ram_en_r, ram_addr_r[ADDR_WIDTH]  outputs; ram_dat_read[D_WIDTH]  input  RAM read port, 1-cycle registered latency; read data holds while ram_en_r=0.
REQ-014 SHALL have ports busy  output  1  high outside IDLE; done  output  1  one-cycle job-complete pulse.

Function
REQ-015 SHALL implement states IDLE, FILL, REPLAY, DONE.
REQ-016 In IDLE with start=1: latch cfg_len (saturated to 2**A_WIDTH) and cfg_npass; if the latched length is 0, go to DONE; otherwise go to FILL if cfg_fill=1, else go to REPLAY.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 FILL: in_ready=1; on each in_valid&&in_ready, ram_we=ram_en_w=1, ram_di=in_data (combinational), ram_addr_w=write counter (0..len-1), then increment the counter.
REQ-019 FILL: the accepted word at address len-1 SHALL move the block to REPLAY, or to DONE if npass=0; in_ready=0 in every state other than FILL.
REQ-020 REPLAY: a read SHALL be issued (ram_en_r=1) when reads remain and (out_valid=0 or out_ready=1); ram_addr_r=read counter.
REQ-021 The cycle after an issue: out_valid=1, out_data=ram_dat_read (passed through, no extra register); out_last=1 iff the issued address was len-1.
REQ-022 With out_valid=1 and out_ready=0, no read SHALL be issued and out_data/out_last SHALL hold stable.
REQ-023 Sustained out_ready=1 SHALL give one word per cycle, including across pass boundaries; the read counter wraps len-1 -> 0 and the pass counter increments.
REQ-024 After the final word of pass npass is consumed (out_valid&&out_ready, no further issue pending): out_valid=0, go to DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-026 Upper address bits [ADDR_WIDTH-1:A_WIDTH] SHALL be driven 0; ram_we/ram_en_w=0 outside FILL and ram_en_r=0 outside REPLAY.

Reset
REQ-027 With reset=1 at a clock edge: state=IDLE; all counters 0; busy, done, out_valid, out_last, in_ready, ram_we, ram_en_w, ram_en_r=0; addresses 0.
REQ-028 Reset mid-FILL or mid-REPLAY SHALL abort the job with no done pulse; RAM contents are not cleared.

Verification
REQ-029 Bench SHALL cover: start, cfg_fill=1, len=4, npass=2, data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4,1,2,3,4 back-to-back, out_last on both 4s, done 1 cycle after the last beat.
REQ-030 Bench SHALL cover: same job with out_ready toggling 1,0 every cycle -> identical sequence, out_data stable while stalled, no duplicated or dropped words.
REQ-031 Bench SHALL cover: second job with cfg_fill=0, len=4, npass=1 -> 1,2,3,4 replayed, in_ready stays 0.
REQ-032 Bench SHALL cover: len=0 -> done pulse on the second cycle after start, no RAM access; len=128, npass=0 -> 128 writes, no reads, then done.
REQ-033 Bench SHALL cover: reset asserted during pass 1 of REPLAY -> next cycle all outputs 0, state IDLE; a new start is accepted immediately.
REQ-034 Bench SHALL cover: start pulsed while busy -> ignored, latched configuration unchanged.
